// File: rtl/cv32e40p_ex_wb_arbiter_pkg.sv
// Shared types, default sizes and helpers for the EX write-back arbiter.
package cv32e40p_ex_wb_arbiter_pkg;

  localparam int unsigned WB_NUM_SRC      = 2;
  localparam int unsigned WB_FIFO_DEPTH   = 2;
  localparam int unsigned WB_ADDR_W       = 6;
  localparam int unsigned WB_DATA_W       = 32;
  localparam int unsigned WB_STARVE_LIMIT = 4;

  // One buffered write-back result at the default widths.
  typedef struct packed {
    logic [WB_ADDR_W-1:0] waddr;
    logic [WB_DATA_W-1:0] wdata;
  } wb_entry_t;

  // Wraps an index that can be at most one lap past n back into [0, n).
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cv32e40p_ex_wb_arbiter_if.sv
// Producer-side result handshake: one valid/ready/waddr/wdata lane per source.
interface cv32e40p_ex_wb_arbiter_if
  import cv32e40p_ex_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC = WB_NUM_SRC,
  parameter int unsigned ADDR_W  = WB_ADDR_W,
  parameter int unsigned DATA_W  = WB_DATA_W
);
  logic [NUM_SRC-1:0]             valid;
  logic [NUM_SRC-1:0]             ready;
  logic [NUM_SRC-1:0][ADDR_W-1:0] waddr;
  logic [NUM_SRC-1:0][DATA_W-1:0] wdata;

  modport master (output valid, waddr, wdata, input ready);
  modport slave  (input valid, waddr, wdata, output ready);
endinterface

// File: rtl/cv32e40p_ex_wb_arbiter_fifo.sv
// Per-source result FIFO with head-age tracking and a per-slot waddr view
// for the dependency compare. Caller never pushes when full or pops when empty.
module cv32e40p_wb_fifo
  import cv32e40p_ex_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = WB_FIFO_DEPTH,
  parameter int unsigned ADDR_W       = WB_ADDR_W,
  parameter int unsigned DATA_W       = WB_DATA_W,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic                         pop_i,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [ADDR_W-1:0]            head_waddr_o,
  output logic [DATA_W-1:0]            head_wdata_o,
  output logic                         aged_o,
  output logic [DEPTH-1:0]             slot_vld_o,
  output logic [DEPTH-1:0][ADDR_W-1:0] slot_waddr_o
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [DEPTH-1:0]   vld_q, vld_d;
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AGE_W-1:0]   age_q, age_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o      = ~|vld_q;
  assign full_o       = &vld_q;
  assign head_waddr_o = mem_q[rd_q].waddr;
  assign head_wdata_o = mem_q[rd_q].wdata;
  assign aged_o       = (age_q == AGE_W'(STARVE_LIMIT));
  assign slot_vld_o   = vld_q;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    assign slot_waddr_o[k] = mem_q[k].waddr;
  end

  // Next storage, occupancy, pointers and head age; age restarts whenever the head changes.
  always_comb begin
    mem_d = mem_q;
    vld_d = vld_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    age_d = age_q;
    if (pop_i) begin
      vld_d[rd_q] = 1'b0;
      rd_d        = ptr_inc(rd_q);
    end
    if (push_i) begin
      mem_d[wr_q] = '{waddr: waddr_i, wdata: wdata_i};
      vld_d[wr_q] = 1'b1;
      wr_d        = ptr_inc(wr_q);
    end
    if (empty_o || pop_i)                    age_d = '0;
    else if (age_q != AGE_W'(STARVE_LIMIT))  age_d = age_q + 1'b1;
  end

  // Control state; reset discards all entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      age_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      age_q <= age_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by vld_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cv32e40p_ex_wb_arbiter.sv
// EX-stage write-back arbiter: the pipeline result owns the RF port unless a
// buffered head has aged out; buffered results drain round-robin in idle slots.
module cv32e40p_ex_wb_arbiter
  import cv32e40p_ex_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC      = WB_NUM_SRC,
  parameter int unsigned FIFO_DEPTH   = WB_FIFO_DEPTH,
  parameter int unsigned ADDR_W       = WB_ADDR_W,
  parameter int unsigned DATA_W       = WB_DATA_W,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  cv32e40p_ex_wb_arbiter_if.slave   src,
  input  logic                      alu_we_i,
  input  logic [ADDR_W-1:0]         alu_waddr_i,
  input  logic [DATA_W-1:0]         alu_wdata_i,
  output logic                      rf_we_o,
  output logic [ADDR_W-1:0]         rf_waddr_o,
  output logic [DATA_W-1:0]         rf_wdata_o,
  output logic                      ex_stall_o,
  input  logic [2:0][ADDR_W-1:0]    chk_addr_i,
  input  logic [2:0]                chk_valid_i,
  output logic                      dep_o,
  output logic [NUM_SRC-1:0]        pending_o,
  output logic                      contention_o
);
  localparam int unsigned RR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]                             full, empty, aged, push, pop;
  logic [NUM_SRC-1:0]                             starved, cand;
  logic [NUM_SRC-1:0][ADDR_W-1:0]                 head_waddr;
  logic [NUM_SRC-1:0][DATA_W-1:0]                 head_wdata;
  logic [NUM_SRC-1:0][FIFO_DEPTH-1:0]             slot_vld;
  logic [NUM_SRC-1:0][FIFO_DEPTH-1:0][ADDR_W-1:0] slot_waddr;
  logic                                           starve, gnt_vld;
  logic [RR_W-1:0]                                gnt_idx, rr_q, rr_d;

  assign src.ready = ~full;
  assign push      = src.valid & ~full;
  assign pending_o = ~empty;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    cv32e40p_wb_fifo #(
      .DEPTH        (FIFO_DEPTH),
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push[g]),
      .waddr_i      (src.waddr[g]),
      .wdata_i      (src.wdata[g]),
      .pop_i        (pop[g]),
      .full_o       (full[g]),
      .empty_o      (empty[g]),
      .head_waddr_o (head_waddr[g]),
      .head_wdata_o (head_wdata[g]),
      .aged_o       (aged[g]),
      .slot_vld_o   (slot_vld[g]),
      .slot_waddr_o (slot_waddr[g])
    );
  end

  // Priority select: starved heads, then the pipeline, then any buffered head; RR within a class.
  always_comb begin
    starved = ~empty & aged;
    starve  = |starved;
    cand    = starve ? starved : (alu_we_i ? '0 : ~empty);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned off = 0; off < NUM_SRC; off++) begin
      if (!gnt_vld && cand[rr_wrap(int'(rr_q) + off, NUM_SRC)]) begin
        gnt_vld = 1'b1;
        gnt_idx = RR_W'(rr_wrap(int'(rr_q) + off, NUM_SRC));
      end
    end
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      pop[s] = gnt_vld && (gnt_idx == RR_W'(s));
    end
    rr_d = rr_q;
    if (gnt_vld) rr_d = (gnt_idx == RR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Register-file port mux and status; stall depends on registered state only.
  always_comb begin
    rf_we_o      = gnt_vld | alu_we_i;
    rf_waddr_o   = gnt_vld ? head_waddr[gnt_idx] : alu_waddr_i;
    rf_wdata_o   = gnt_vld ? head_wdata[gnt_idx] : alu_wdata_i;
    ex_stall_o   = starve;
    contention_o = alu_we_i & ~starve & |pending_o;
  end

  // ID hazard check against buffered and in-flight results; x0 is never a hazard.
  always_comb begin
    dep_o = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (chk_valid_i[c] && (chk_addr_i[c] != '0)) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (push[s] && (src.waddr[s] == chk_addr_i[c])) dep_o = 1'b1;
          for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (slot_vld[s][k] && (slot_waddr[s][k] == chk_addr_i[c])) dep_o = 1'b1;
          end
        end
      end
    end
  end

  // Round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

endmodule
